// File: rtl/pipe_drain_fifo.sv
// -----------------------------------------------------------------------------
// pipe_drain_fifo
//
// Elastic capture buffer that sits after the free-running arithmetic pipelines.
// The upstream pipelines cannot stall, so every valid result is captured when
// there is room for it. Results leave through a valid/ready handshake.
// almost_full gives issue logic an early warning so it can stop launching
// operations. overflow is a sticky flag that records a result lost to a full
// buffer.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      pipeline result valid this cycle (no backpressure)
//   in_data       pipeline result word
//   out_valid     head entry available
//   out_ready     consumer takes the head entry this cycle
//   out_data      head entry
//   almost_full   occupancy >= DEPTH - AFULL_MARGIN
//   count         current occupancy, 0..DEPTH
//   overflow      sticky, a result was dropped
//   clr_overflow  synchronous clear of overflow (a drop in the same cycle wins)
// -----------------------------------------------------------------------------
module pipe_drain_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = PW + 1;
    localparam int AF_LEVEL = DEPTH - AFULL_MARGIN;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             overflow_q, overflow_d;

    logic push;
    logic pop;
    logic drop;

    // A full buffer can still accept a word when the head leaves in the same
    // cycle, because the slot being read is the one the write pointer targets.
    assign pop  = (count_q != '0) && out_ready;
    assign push = in_valid && ((count_q < CW'(DEPTH)) || pop);
    assign drop = in_valid && !push;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        // DEPTH is a power of two, so the pointers wrap naturally.
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over clear, so a drop is never hidden by a clear.
        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the values from before the edge, whatever order the statements run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is reset on purpose. After a reset out_data must
    // read zero and must not show stale words. That costs a reset on each
    // storage flop, which is acceptable at this depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // All outputs come from registers. No path runs from in_* to the outputs,
    // so a word written into an empty buffer shows up one cycle later.
    assign out_valid   = (count_q != '0);
    assign out_data    = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign almost_full = (count_q >= CW'(AF_LEVEL));
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// -----------------------------------------------------------------------------
// tb_pipe_drain_fifo
//
// Directed bench for pipe_drain_fifo with WIDTH=32, DEPTH=4, AFULL_MARGIN=2.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_pipe_drain_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AFM   = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             almost_full;
    logic [2:0]       count;
    logic             overflow;
    logic             clr_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_drain_fifo #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (AFM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] exp_q [4];

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;

        // ---------------- reset values ----------------
        step();
        step();
        check("rst_count",     64'(count),       64'd0);
        check("rst_out_valid", 64'(out_valid),   64'd0);
        check("rst_af",        64'(almost_full), 64'd0);
        check("rst_overflow",  64'(overflow),    64'd0);
        check("rst_out_data",  64'(out_data),    64'd0);
        rst_n = 1'b1;

        // ---- idle, with out_ready high while empty (must be ignored) ----
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_count",     64'(count),     64'd0);
            check("idle_out_valid", 64'(out_valid), 64'd0);
        end
        out_ready = 1'b0;

        // ---------------- fill A0..A3 ----------------
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + 32'(i);
            step();
            check("fill_count",    64'(count),       64'(i + 1));
            check("fill_af",       64'(almost_full), 64'((i + 1) >= 2));
            check("fill_head",     64'(out_data),    64'hA0);
            check("fill_outvalid", 64'(out_valid),   64'd1);
        end

        // ---------------- overflow ----------------
        in_data = 32'hBB;
        step();
        check("ovf_set",   64'(overflow), 64'd1);
        check("ovf_count", 64'(count),    64'd4);
        check("ovf_head",  64'(out_data), 64'hA0);

        in_data      = 32'hBC;
        clr_overflow = 1'b1;
        step();
        check("ovf_set_wins", 64'(overflow), 64'd1);
        check("ovf_count2",   64'(count),    64'd4);

        in_valid = 1'b0;
        step();
        check("ovf_cleared", 64'(overflow), 64'd0);
        clr_overflow = 1'b0;

        // ---------------- drain ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 64'(out_data), 64'(32'hA0 + 32'(i)));
            step();
            check("drain_count", 64'(count),       64'(3 - i));
            check("drain_af",    64'(almost_full), 64'((3 - i) >= 2));
        end
        check("drain_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // ---------------- full + simultaneous pop ----------------
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + 32'(i);
            step();
        end
        check("fp_full", 64'(count), 64'd4);
        in_data   = 32'hCC;
        out_ready = 1'b1;
        step();
        check("fp_count",    64'(count),    64'd4);
        check("fp_overflow", 64'(overflow), 64'd0);
        check("fp_head",     64'(out_data), 64'hC1);
        in_valid = 1'b0;
        exp_q[0] = 32'hC1;
        exp_q[1] = 32'hC2;
        exp_q[2] = 32'hC3;
        exp_q[3] = 32'hCC;
        for (int i = 0; i < 4; i++) begin
            check("fp_order", 64'(out_data), 64'(exp_q[i]));
            step();
        end
        check("fp_empty", 64'(count), 64'd0);

        // ---------------- streaming wrap-around ----------------
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            step();
            check("strm_valid", 64'(out_valid), 64'd1);
            check("strm_data",  64'(out_data),  64'(i));
            check("strm_count", 64'(count),     64'd1);
        end
        in_valid = 1'b0;
        step();
        check("strm_end_count", 64'(count),     64'd0);
        check("strm_end_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hE0 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        check("mr_count3", 64'(count), 64'd3);
        #3;                       // mid-cycle, no clock edge before the checks
        rst_n = 1'b0;
        #1;
        check("mr_count",     64'(count),       64'd0);
        check("mr_out_valid", 64'(out_valid),   64'd0);
        check("mr_out_data",  64'(out_data),    64'd0);
        check("mr_af",        64'(almost_full), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("mr_idle_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'hD1;
        step();
        in_valid = 1'b0;
        check("mr_d1_valid", 64'(out_valid), 64'd1);
        check("mr_d1_data",  64'(out_data),  64'hD1);
        check("mr_d1_count", 64'(count),     64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_drain_fifo.md
# pipe_drain_fifo

Small elastic capture buffer placed directly downstream of the free-running register pipelines (mantissa/product stages, 10-cycle delay lines). Those pipelines cannot stall, so this block absorbs every valid result they emit and presents it to a consumer through a valid/ready handshake. It raises an early-warning flag so issue logic can stop launching operations while results are still in flight. It also records a sticky error if a result is lost.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 4, number of storage entries; power of two, ≥ 2
- AFULL_MARGIN, 2, `almost_full` asserts when count ≥ DEPTH − AFULL_MARGIN; range 0..DEPTH−1

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  pipeline result valid this cycle; no backpressure path
- in_data  in  WIDTH  pipeline result
- out_valid  out  1  entry available at head
- out_ready  in  1  consumer accepts head this cycle
- out_data  out  WIDTH  head entry
- almost_full  out  1  occupancy warning to issue logic
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a result was dropped
- clr_overflow  in  1  synchronous clear of `overflow`

## Operation
- Circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits each, plus an occupancy counter; pointers wrap DEPTH−1 → 0.
- push = in_valid && (count < DEPTH || pop). pop = out_valid && out_ready.
- On push: mem[wr_ptr] ← in_data and wr_ptr++.
- On pop: rd_ptr++.
- count next = count + push − pop. Simultaneous push and pop leave count unchanged.
- Full with in_valid and no pop: word discarded; mem, pointers and count unchanged; overflow ← 1.
- Full with in_valid and pop in the same cycle: word accepted, no overflow.
- out_valid = (count != 0). out_data = mem[rd_ptr]. Both are driven from registers with no combinational path from in_*.
- No bypass: a word written into an empty buffer becomes visible the following cycle.
- almost_full = (count ≥ DEPTH − AFULL_MARGIN), evaluated on registered count.
- Overflow register: set if a drop occurs, else cleared if clr_overflow is 1, else hold. Set wins over clear in the same cycle.
- out_ready while out_valid = 0 is ignored; no state change.
- Data order is strictly preserved (FIFO).

## Timing
- Reset (rst_n low, asynchronous): count = 0, out_valid = 0, almost_full = 0 (or 1 if DEPTH − AFULL_MARGIN = 0), overflow = 0, pointers = 0, all mem entries = 0, so out_data = 0.
- Reset deassertion is sampled on clk. The first push is possible on the first rising edge with rst_n high.
- Reset mid-operation discards all contents immediately; outputs take their reset values asynchronously.
- Latency: in_valid at edge N → out_valid/out_data valid after edge N+1, i.e. 1 cycle.
- Throughput: one push and one pop per cycle sustained, with count steady.
- count, almost_full, out_valid and overflow all update on the same edge as the event that causes them.
- Handshake: once out_valid is asserted, out_data is stable until a pop occurs.

## Test plan
- Reset/idle: assert rst_n low mid-cycle → all outputs at reset values without a clock edge. Release rst_n, then drive in_valid=0 for 5 cycles → count stays 0, out_valid stays 0.
- Fill/drain order (WIDTH=32, DEPTH=4, margin 2): push 0xA0..0xA3 on consecutive cycles with out_ready=0.
  - Expected: count 1,2,3,4; almost_full rises when count reaches 2.
  - Then out_ready=1 → out_data sequence 0xA0,0xA1,0xA2,0xA3, count back to 0, almost_full drops at count 1.
- Overflow: with buffer full, push 0xBB while out_ready=0 → 0xBB dropped, overflow=1, count=4, head still 0xA0.
  - Assert clr_overflow together with another drop → overflow stays 1.
  - Assert clr_overflow alone → overflow=0 next cycle.
- Full + simultaneous pop: full buffer, in_valid=1 with 0xCC and out_ready=1 → pops the head, count stays 4, overflow stays 0, and 0xCC emerges fourth.
- Streaming wrap-around: push 0x00..0x0F on 16 consecutive cycles with out_ready held at 1.
  - Expected: outputs 0x00..0x0F in order, each one cycle after its push; count never exceeds 1; pointers wrap four times.
- Reset mid-operation: reach count=3, pull rst_n low → count=0, out_valid=0 immediately. After release, push 0xD1 → out_data=0xD1 next cycle, with no stale data visible.
